// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: load func3 encodings, data width default and retire-queue entry type.
package writeback_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]              rd;
        logic                    we;
        logic                    is_load;
        logic [2:0]              func3;
        logic [1:0]              addr_lo;
        logic [XLEN_DEFAULT-1:0] data;
        logic                    ready;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: picks the addressed byte/halfword/word out of a memory word and extends it.
module load_align
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      func3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
        half_v = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        data_o = func3_i == F3_LB  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
                 func3_i == F3_LBU ? {{(XLEN-8){1'b0}}, byte_v} :
                 func3_i == F3_LH  ? {{(XLEN-16){half_v[15]}}, half_v} :
                 func3_i == F3_LHU ? {{(XLEN-16){1'b0}}, half_v} :
                 func3_i == F3_LW  ? word_i : '0;
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: in-order retire queue merging load responses, one register write per cycle.
// Define WB_RETIRE_COUNT_EN to add the 64-bit Retire_Count output.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Valid_MEM,
    input  logic            Write_Enable_MEM,
    input  logic            Is_Load_MEM,
    input  logic [4:0]      rd_MEM,
    input  logic [2:0]      Func3_MEM,
    input  logic [1:0]      Addr_Lo_MEM,
    input  logic [XLEN-1:0] Result_MEM,
    input  logic            Load_Data_Valid,
    input  logic [XLEN-1:0] Load_Data,
    output logic            Stall_MEM,
    output logic            Write_Enable_WB,
    output logic [4:0]      rd_WB,
    output logic [XLEN-1:0] Data_in,
    output logic            Load_Error
`ifdef WB_RETIRE_COUNT_EN
    ,output logic [63:0]    Retire_Count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       q_q [DEPTH];
    wb_entry_t       q_d [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d, hit_idx;
    logic [CW-1:0]   count_q, count_d;
    logic            hit, ld_hit, push, pop, we_d, err_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] data_d, aligned;

    // Oldest still-waiting load among entries that were already queued.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && CW'(i) < count_q && q_q[head_q + AW'(i)].is_load && !q_q[head_q + AW'(i)].ready) begin
                hit     = 1'b1;
                hit_idx = head_q + AW'(i);
            end
        end
    end

    load_align #(.XLEN(XLEN)) u_align (
        .word_i    (Load_Data),
        .func3_i   (q_q[hit_idx].func3),
        .addr_lo_i (q_q[hit_idx].addr_lo),
        .data_o    (aligned)
    );

    always_comb begin
        Stall_MEM = count_q == CW'(DEPTH);
        push      = Valid_MEM && !Stall_MEM;
        pop       = count_q != '0 && q_q[head_q].ready;
        ld_hit    = Load_Data_Valid && hit;
        q_d       = q_q;
        if (pop)
            q_d[head_q].ready = 1'b0;
        if (push)
            q_d[tail_q] = '{rd: rd_MEM, we: Write_Enable_MEM, is_load: Is_Load_MEM, func3: Func3_MEM,
                            addr_lo: Addr_Lo_MEM, data: Is_Load_MEM ? '0 : Result_MEM, ready: !Is_Load_MEM};
        if (ld_hit) begin
            q_d[hit_idx].data  = aligned;
            q_d[hit_idx].ready = 1'b1;
        end
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        we_d    = pop && q_q[head_q].we && q_q[head_q].rd != 5'd0;
        rd_d    = pop ? q_q[head_q].rd : rd_WB;
        data_d  = pop ? q_q[head_q].data : Data_in;
        err_d   = Load_Error || (Load_Data_Valid && !hit);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++)
                q_q[i] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            Write_Enable_WB <= 1'b0;
            rd_WB           <= '0;
            Data_in         <= '0;
            Load_Error      <= 1'b0;
        end else begin
            q_q             <= q_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            Write_Enable_WB <= we_d;
            rd_WB           <= rd_d;
            Data_in         <= data_d;
            Load_Error      <= err_d;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Retire_Count <= '0;
        else
            Retire_Count <= Retire_Count + 64'(pop);
    end
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back end of the pipeline. Feeds the decode stage's register-file write port: `Write_Enable_WB`, `rd_WB` and `Data_in`. The decode stage samples these on negedge `Clk`.
- Accepts completed MEM-stage results into a small in-order retire queue.
- Merges variable-latency load responses into the queue, then aligns and sign/zero-extends them.
- Issues at most one register write per cycle, in program order.

Parameters:
- `DEPTH`, 4: retire-queue entries. Power of two, ≥ 2.
- `XLEN`, 32: data width.

Ports:
- `Clk` input 1: clock. All state updates on posedge.
- `Reset` input 1: asynchronous, active-high reset.
- `Valid_MEM` input 1: a MEM-stage instruction is presented.
- `Write_Enable_MEM` input 1: the instruction writes rd.
- `Is_Load_MEM` input 1: the instruction is a load; result comes from `Load_Data`.
- `rd_MEM` input 5: destination register.
- `Func3_MEM` input 3: load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `Addr_Lo_MEM` input 2: low bits of the load address.
- `Result_MEM` input XLEN: ALU/AUIPC/LUI/link result for non-loads.
- `Load_Data_Valid` input 1: a data-memory response is present. Responses arrive in load order.
- `Load_Data` input XLEN: raw 32-bit memory word.
- `Stall_MEM` output 1: queue full. Combinational, equals (count == DEPTH).
- `Write_Enable_WB` output 1: register write strobe. Registered.
- `rd_WB` output 5: write address. Registered.
- `Data_in` output XLEN: write data. Registered.
- `Load_Error` output 1: sticky; set by an unmatched load response.

Behaviour:
- Reset (async, any time, including mid-operation):
  - All outputs go to 0 immediately.
  - Queue is emptied; head, tail and count go to 0; all ready bits are cleared.
  - Pending loads are dropped. Any response for them arriving after reset deassertion counts as unmatched.
- Entry fields: `rd`, `we`, `is_load`, `func3`, `addr_lo`, `data`, `ready`.
- Push:
  - Occurs at posedge when `Valid_MEM` && !`Stall_MEM`.
  - Non-load entries: `data` = `Result_MEM`, `ready` = 1.
  - Load entries: `ready` = 0.
  - `Valid_MEM` while `Stall_MEM` is ignored; upstream holds the instruction.
- Load response:
  - On `Load_Data_Valid`, the word is written into the oldest entry (searched from head) with `is_load` && !`ready` that existed before this edge. That entry's `ready` is set to 1.
  - No such entry (including an empty queue, or a load pushed at this same edge): data is discarded and `Load_Error` is set to 1 until Reset.
- Load extraction is applied on write into the entry:
  - LB/LBU: byte `addr_lo`, sign- or zero-extended.
  - LH/LHU: halfword `addr_lo[1]`, sign- or zero-extended.
  - LW: whole word.
  - Any other func3 yields 0.
- Retire:
  - When the head entry is `ready`, it pops at posedge.
  - At the same edge, `Write_Enable_WB` <= `we` && (`rd` != 0), `rd_WB` <= `rd`, `Data_in` <= `data`.
  - Otherwise `Write_Enable_WB` <= 0; `rd_WB` and `Data_in` hold their values.
- Latency:
  - Non-load presented in cycle k with queue empty: pushed at edge k, written at edge k+1. Strobe is high during cycle k+1.
  - Load: retires at the edge after its response, if it is the head.
- Push and pop at the same edge:
  - Both occur; count is unchanged.
  - Push is still blocked when full at the start of the cycle. `Stall_MEM` reflects current count, not the pending pop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Entries with `we` = 0 (stores, branches) still occupy a slot and retire in order with the strobe low.

Optional Feature:
- Macro `WB_RETIRE_COUNT_EN`.
- Defined:
  - Adds output `Retire_Count` [63:0], reset to 0.
  - Increments by 1 at every pop, whether or not `we` is set.
  - Wraps at 2^64.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Load func3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - The retire-entry struct typedef.
  - The XLEN default.
- One natural sub-module, `load_align`: combinational extraction from (word, func3, `addr_lo`) to XLEN. It is reusable by the MEM stage.

Test Plan:
1. ALU write, then stall:
   - Stimulus: Reset, then push non-load rd=5, `Result_MEM`=0x1234 in cycle 1.
   - Required: `Write_Enable_WB`=1, `rd_WB`=5, `Data_in`=0x1234 in cycle 2, then 0.
   - Push 4 more with no pop opportunity blocked: `Stall_MEM` stays 0 until 4 pending loads are queued, then 1.
2. Load ordering:
   - Stimulus: push load LB rd=3 `addr_lo`=2, then ALU rd=4 (0x7); respond `Load_Data`=0x0080FF00 two cycles later.
   - Required: nothing written before the response; then rd=3 Data=0xFFFFFF80, next cycle rd=4 Data=0x7.
3. Extraction coverage on word 0x8001F0F7:
   - LBU addr 0 → 0x000000F7.
   - LH addr 2 → 0xFFFF8001.
   - LHU addr 0 → 0x0000F0F7.
   - LW → 0x8001F0F7.
4. x0 and no-write entries:
   - Push rd=0 `Result_MEM`=0xDEAD with `we`=1, then a store (`we`=0).
   - Required: `Write_Enable_WB` stays 0 for both; both pop (count returns to 0).
5. Unmatched response:
   - `Load_Data_Valid` with an empty queue → `Load_Error`=1, stays set, no write.
   - Reset clears it.
6. Reset mid-flight:
   - Two loads pending, assert Reset between edges.
   - Required: outputs 0 immediately, `Stall_MEM`=0.
   - Late response after reset → `Load_Error`=1.
   - With `WB_RETIRE_COUNT_EN`: 3 retirements → `Retire_Count`=3.
